// File: rtl/ascon_permutation_iter.sv
// Round-iterative Ascon permutation p^n (n = 1..12) with a start/busy/done handshake.
// UNROLL rounds are evaluated per clock; unused stages of the last cycle are bypassed.
module ascon_permutation_iter #(
   parameter int UNROLL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [3:0]  rounds_i,
   input  logic [63:0] x0_i,
   input  logic [63:0] x1_i,
   input  logic [63:0] x2_i,
   input  logic [63:0] x3_i,
   input  logic [63:0] x4_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [63:0] x0_o,
   output logic [63:0] x1_o,
   output logic [63:0] x2_o,
   output logic [63:0] x3_o,
   output logic [63:0] x4_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [3:0] UNROLL_W = 4'(UNROLL);

   logic [1:0]   state_r;
   logic [3:0]   rc_r;
   logic [63:0]  x0_r, x1_r, x2_r, x3_r, x4_r;
   logic         busy_r;
   logic         done_r;
   logic [3:0]   n_s;
   logic [3:0]   rc_load_s;
   logic [3:0]   rc_next_s;
   logic [319:0] perm_s;

   function automatic logic [319:0] round_f(input logic [319:0] s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128];
      x3 = s[127:64];
      x4 = s[63:0];
      x2 = x2 ^ {56'd0, 4'd15 - r, r};
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
      x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
      x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
      x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
      x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
      return {x0, x1, x2, x3, x4};
   endfunction

   // Clamp the requested round count and derive the starting round index.
   always_comb begin
      if ((rounds_i == 4'd0) || (rounds_i > 4'd12)) begin
         n_s = 4'd12;
      end else begin
         n_s = rounds_i;
      end
      rc_load_s = 4'd12 - n_s;
   end

   // Round counter advance, saturating at 12 on a partial final cycle.
   always_comb begin
      if ((4'd12 - rc_r) <= UNROLL_W) begin
         rc_next_s = 4'd12;
      end else begin
         rc_next_s = rc_r + UNROLL_W;
      end
   end

   // Unrolled round chain; stages past round 11 pass the state through.
   always_comb begin
      perm_s = {x0_r, x1_r, x2_r, x3_r, x4_r};
      for (int j = 0; j < UNROLL; j++) begin
         if (({1'b0, rc_r} + 5'(j)) < 5'd12) begin
            perm_s = round_f(perm_s, rc_r + 4'(j));
         end else begin
            perm_s = perm_s;
         end
      end
   end

   // Control FSM and working/result state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         rc_r    <= 4'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         x0_r    <= 64'd0;
         x1_r    <= 64'd0;
         x2_r    <= 64'd0;
         x3_r    <= 64'd0;
         x4_r    <= 64'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start_i) begin
                  x0_r    <= x0_i;
                  x1_r    <= x1_i;
                  x2_r    <= x2_i;
                  x3_r    <= x3_i;
                  x4_r    <= x4_i;
                  rc_r    <= rc_load_s;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               {x0_r, x1_r, x2_r, x3_r, x4_r} <= perm_s;
               rc_r <= rc_next_s;
               if (rc_next_s == 4'd12) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_r;
   assign done_o = done_r;
   assign x0_o   = x0_r;
   assign x1_o   = x1_r;
   assign x2_o   = x2_r;
   assign x3_o   = x3_r;
   assign x4_o   = x4_r;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Directed bench for ascon_permutation_iter: three instances (UNROLL 1, 2, 4) share stimulus
// and are checked against hand vectors and a table-driven Ascon reference model.
module tb_ascon_permutation_iter;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int UNR [3] = '{1, 2, 4};

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  rounds;
   logic [63:0] x_in [5];
   logic        busy_s [3];
   logic        done_s [3];
   logic [63:0] xo [3][5];

   int           n_checks = 0;
   int           n_fail   = 0;
   int           meas_edge [3];
   int           meas_busy [3];
   logic         meas_busy_done [3];
   logic [319:0] meas_res [3];

   always #5 clk = ~clk;

   ascon_permutation_iter #(.UNROLL(1)) u1 (
      .clk(clk), .rst(rst), .start_i(start), .rounds_i(rounds),
      .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
      .busy_o(busy_s[0]), .done_o(done_s[0]),
      .x0_o(xo[0][0]), .x1_o(xo[0][1]), .x2_o(xo[0][2]), .x3_o(xo[0][3]), .x4_o(xo[0][4]));

   ascon_permutation_iter #(.UNROLL(2)) u2 (
      .clk(clk), .rst(rst), .start_i(start), .rounds_i(rounds),
      .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
      .busy_o(busy_s[1]), .done_o(done_s[1]),
      .x0_o(xo[1][0]), .x1_o(xo[1][1]), .x2_o(xo[1][2]), .x3_o(xo[1][3]), .x4_o(xo[1][4]));

   ascon_permutation_iter #(.UNROLL(4)) u4 (
      .clk(clk), .rst(rst), .start_i(start), .rounds_i(rounds),
      .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
      .busy_o(busy_s[2]), .done_o(done_s[2]),
      .x0_o(xo[2][0]), .x1_o(xo[2][1]), .x2_o(xo[2][2]), .x3_o(xo[2][3]), .x4_o(xo[2][4]));

   function automatic logic [319:0] get_out(input int i);
      return {xo[i][0], xo[i][1], xo[i][2], xo[i][3], xo[i][4]};
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Reference model: column-wise S-box table lookup, unlike the boolean form in the design
   function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
      logic [63:0] w [5];
      logic [4:0]  idx;
      logic [4:0]  v;
      for (int i = 0; i < 5; i++) w[i] = s[319 - 64*i -: 64];
      for (int r = 12 - n; r < 12; r++) begin
         w[2] = w[2] ^ 64'((15 - r) * 16 + r);
         for (int b = 0; b < 64; b++) begin
            idx = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
            v   = SBOX[idx];
            w[0][b] = v[4];
            w[1][b] = v[3];
            w[2][b] = v[2];
            w[3][b] = v[1];
            w[4][b] = v[0];
         end
         w[0] = w[0] ^ ror(w[0], 19) ^ ror(w[0], 28);
         w[1] = w[1] ^ ror(w[1], 61) ^ ror(w[1], 39);
         w[2] = w[2] ^ ror(w[2], 1)  ^ ror(w[2], 6);
         w[3] = w[3] ^ ror(w[3], 10) ^ ror(w[3], 17);
         w[4] = w[4] ^ ror(w[4], 7)  ^ ror(w[4], 41);
      end
      return {w[0], w[1], w[2], w[3], w[4]};
   endfunction

   function automatic logic [319:0] rand_state();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic set_state(input logic [319:0] s);
      for (int i = 0; i < 5; i++) x_in[i] = s[319 - 64*i -: 64];
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Start one job on all instances; record done edge (start edge = 0), busy cycles and result
   task automatic run_job(input logic [3:0] n, input logic [319:0] s);
      bit all_seen;
      @(negedge clk);
      rounds = n;
      set_state(s);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         meas_edge[i] = -1;
         meas_busy[i] = 0;
         meas_busy_done[i] = 1'bx;
         meas_res[i] = '0;
      end
      for (int k = 0; k < 40; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         all_seen = 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (meas_edge[i] < 0) begin
               if (done_s[i] === 1'b1) begin
                  meas_edge[i] = k;
                  meas_res[i] = get_out(i);
                  meas_busy_done[i] = busy_s[i];
               end else if (busy_s[i] === 1'b1) begin
                  meas_busy[i]++;
               end
            end
            if (meas_edge[i] < 0) all_seen = 1'b0;
         end
         if (all_seen) break;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_job(input string name, input int n_eff, input logic [319:0] exp_res);
      int c;
      for (int i = 0; i < 3; i++) begin
         c = (n_eff + UNR[i] - 1) / UNR[i];
         n_checks++;
         if (meas_edge[i] !== c) begin
            n_fail++;
            $display("FAIL %s_latency u%0d: done after edge %0d, expected %0d", name, UNR[i], meas_edge[i], c);
         end
         n_checks++;
         if (meas_busy[i] !== c) begin
            n_fail++;
            $display("FAIL %s_busy u%0d: busy cycles %0d, expected %0d", name, UNR[i], meas_busy[i], c);
         end
         n_checks++;
         if (meas_busy_done[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_at_done u%0d: busy %b, expected 0", name, UNR[i], meas_busy_done[i]);
         end
         n_checks++;
         if (meas_res[i] !== exp_res) begin
            n_fail++;
            $display("FAIL %s_result u%0d: got %h expected %h", name, UNR[i], meas_res[i], exp_res);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      rounds = 4'd0;
      set_state('0);
      @(posedge clk);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (busy_s[i] !== 1'b0 || done_s[i] !== 1'b0 || get_out(i) !== 320'd0) begin
            n_fail++;
            $display("FAIL reset_state u%0d: busy %b done %b x %h, expected all zero",
                     UNR[i], busy_s[i], done_s[i], get_out(i));
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_single_round();
      logic [319:0] exp_v;
      exp_v = {64'h000964B00000004B, 64'h0000000096000213, 64'h53FFFFFFFFFFFF90,
               64'h12E580000000004B, 64'h0000000000000000};
      run_job(4'd1, 320'd0);
      check_job("single_round", 1, exp_v);
   endtask

   task automatic test_latency();
      int           ns [4] = '{1, 6, 8, 12};
      logic [319:0] s;
      for (int t = 0; t < 4; t++) begin
         s = rand_state();
         run_job(4'(ns[t]), s);
         check_job($sformatf("latency_n%0d", ns[t]), ns[t], model_perm(s, ns[t]));
      end
   endtask

   task automatic test_clamp();
      logic [319:0] s;
      logic [319:0] r12 [3];
      logic [3:0]   nv [2] = '{4'd0, 4'd15};
      s = rand_state();
      run_job(4'd12, s);
      check_job("clamp_ref12", 12, model_perm(s, 12));
      for (int i = 0; i < 3; i++) r12[i] = meas_res[i];
      for (int t = 0; t < 2; t++) begin
         run_job(nv[t], s);
         check_job($sformatf("clamp_n%0d", nv[t]), 12, model_perm(s, 12));
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_res[i] !== r12[i]) begin
               n_fail++;
               $display("FAIL clamp_vs_n12 u%0d: got %h expected %h", UNR[i], meas_res[i], r12[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [319:0] s1, s2;
      int           cnt [3];
      int           edge_v [3][2];
      logic [319:0] res [3][2];
      bit           all_two;
      int           c;
      s1 = rand_state();
      s2 = rand_state();
      @(negedge clk);
      rounds = 4'd6;
      set_state(s1);
      start = 1'b1;
      @(posedge clk);
      #1;
      set_state(s2);
      for (int i = 0; i < 3; i++) begin
         cnt[i] = 0;
         edge_v[i][0] = -1;
         edge_v[i][1] = -1;
         res[i][0] = '0;
         res[i][1] = '0;
      end
      for (int k = 1; k < 40; k++) begin
         @(posedge clk);
         #1;
         all_two = 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (done_s[i] === 1'b1 && cnt[i] < 2) begin
               edge_v[i][cnt[i]] = k;
               res[i][cnt[i]] = get_out(i);
               cnt[i]++;
            end
            if (cnt[i] < 2) all_two = 1'b0;
         end
         if (all_two) break;
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         c = (6 + UNR[i] - 1) / UNR[i];
         n_checks++;
         if (edge_v[i][0] !== c || res[i][0] !== model_perm(s1, 6)) begin
            n_fail++;
            $display("FAIL b2b_first u%0d: edge %0d res %h, expected edge %0d res %h",
                     UNR[i], edge_v[i][0], res[i][0], c, model_perm(s1, 6));
         end
         n_checks++;
         if (edge_v[i][1] !== 2*c + 2 || res[i][1] !== model_perm(s2, 6)) begin
            n_fail++;
            $display("FAIL b2b_second u%0d: edge %0d res %h, expected edge %0d res %h",
                     UNR[i], edge_v[i][1], res[i][1], 2*c + 2, model_perm(s2, 6));
         end
      end
      do_reset();
   endtask

   task automatic test_reset_mid_run();
      int pre [3];
      int post [3];
      for (int i = 0; i < 3; i++) begin
         pre[i] = 0;
         post[i] = 0;
      end
      @(negedge clk);
      rounds = 4'd12;
      set_state(rand_state());
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k < 5; k++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) if (done_s[i] === 1'b1) pre[i]++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (busy_s[i] !== 1'b0 || done_s[i] !== 1'b0 || get_out(i) !== 320'd0) begin
            n_fail++;
            $display("FAIL midrun_reset u%0d: busy %b done %b x %h, expected all zero",
                     UNR[i], busy_s[i], done_s[i], get_out(i));
         end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) if (done_s[i] !== 1'b0) post[i]++;
      end
      // UNROLL=4 finishes p12 before edge 5, so only u1/u2 are mid-run at reset
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (pre[i] !== 0) begin
            n_fail++;
            $display("FAIL midrun_early_done u%0d: %0d pulses, expected 0", UNR[i], pre[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (post[i] !== 0) begin
            n_fail++;
            $display("FAIL midrun_done_after_reset u%0d: %0d pulses, expected 0", UNR[i], post[i]);
         end
      end
   endtask

   task automatic test_random_hold();
      logic [319:0] s;
      int           bad [3];
      s = rand_state();
      run_job(4'd12, s);
      check_job("random_p12", 12, model_perm(s, 12));
      for (int i = 0; i < 3; i++) bad[i] = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (get_out(i) !== meas_res[i] || busy_s[i] !== 1'b0 || done_s[i] !== 1'b0) bad[i]++;
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bad[i] !== 0) begin
            n_fail++;
            $display("FAIL hold_idle u%0d: %0d unstable cycles, expected 0", UNR[i], bad[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      rounds = 4'd0;
      set_state('0);
      test_reset();
      test_single_round();
      test_latency();
      test_clamp();
      test_back_to_back();
      test_reset_mid_run();
      test_random_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
